// File: rtl/uart_word_deserializer.sv
// UART receiver: oversampled 8-bit frames reassembled into WIDTH-bit words.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7 and drive parity_err.
module uart_word_deserializer #(
  parameter int WIDTH        = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rxd,
  output logic [WIDTH-1:0] p,
  output logic             valid,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int NB = WIDTH / 8;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NB) + 1;
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rxs;
  logic             rxs_prev;
  logic [1:0]       settle;
  logic [TW-1:0]    timer;
  logic [2:0]       bit_idx;
  logic [BW-1:0]    byte_idx;
  logic [7:0]       shift_byte;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] word_next;
  logic             fall;
`ifdef UART_RX_PARITY_EN
  logic             par_bad;
`endif

  // Edge detection is held off until the synchronizer carries real line samples,
  // so a line that is already low when reset releases is not seen as a start.
  assign fall = (settle == 2'd3) && rxs_prev && !rxs;

  always_comb begin
    word_next = word;
    word_next[{byte_idx, 3'b000} +: 8] = shift_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      rxs_prev   <= 1'b1;
      settle     <= '0;
      timer      <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shift_byte <= '0;
      word       <= '0;
      p          <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_meta    <= rxd;
      rxs        <= rx_meta;
      rxs_prev   <= rxs;
      if (settle != 2'd3) settle <= settle + 2'd1;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      case (state)
        IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (fall) state <= START;
        end
        START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == T_FULL) begin
            timer               <= '0;
            shift_byte[bit_idx] <= rxs;
            bit_idx             <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer == T_FULL) begin
            timer   <= '0;
            par_bad <= (^shift_byte) ^ rxs;
            state   <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        STOP: begin
          if (timer == T_FULL) begin
            timer <= '0;
            state <= IDLE;
            if (!rxs) begin
              frame_err <= 1'b1;
              byte_idx  <= '0;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_bad) begin
              parity_err <= 1'b1;
              byte_idx   <= '0;
            end
`endif
            else begin
              word <= word_next;
              if (byte_idx == B_LAST) begin
                p        <= word_next;
                valid    <= 1'b1;
                byte_idx <= '0;
              end else begin
                byte_idx <= byte_idx + 1'b1;
              end
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_deserializer.sv
// Directed bench for uart_word_deserializer: 16-cycle-per-bit instance plus a
// 4-cycle-per-bit instance for back-to-back frames.
module tb_uart_word_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        rxd4 = 1'b1;
  logic [15:0] p, p4;
  logic        valid, frame_err, parity_err;
  logic        valid4, frame_err4, parity_err4;

  int checks = 0;
  int errors = 0;
  int vcnt = 0, fcnt = 0, pcnt = 0;
  int vcnt4 = 0, fcnt4 = 0;
  logic [15:0] p_last = '0;
  logic [15:0] q4[$];

  always #5 clk = ~clk;

  uart_word_deserializer #(.WIDTH(16), .CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .p(p),
    .valid(valid), .frame_err(frame_err), .parity_err(parity_err)
  );

  uart_word_deserializer #(.WIDTH(16), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd4), .p(p4),
    .valid(valid4), .frame_err(frame_err4), .parity_err(parity_err4)
  );

  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      p_last = p;
      $display("word p=%h", p);
    end
    if (frame_err)  fcnt++;
    if (parity_err) pcnt++;
    if (valid4) begin
      vcnt4++;
      q4.push_back(p4);
      $display("word4 p=%h", p4);
    end
    if (frame_err4) fcnt4++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok %s = %h", tag, obs);
    end
  endtask

  task automatic line(input bit sel, input logic b, input int n);
    if (sel) rxd4 = b;
    else     rxd  = b;
    repeat (n) @(negedge clk);
  endtask

  // bad_par inverts the even-parity bit when parity is compiled in.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop, input logic bad_par);
    logic [10:0] f;
    int nbits;
    int n;
    n = sel ? 4 : 16;
`ifdef UART_RX_PARITY_EN
    f = {stop, (^d) ^ bad_par, d, 1'b0};
    nbits = 11;
`else
    f = {bad_par, stop, d, 1'b0};
    nbits = 10;
`endif
    for (int i = 0; i < nbits; i++) line(sel, f[i], n);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_frame(1'b0, w[7:0], 1'b1, 1'b0);
    send_frame(1'b0, w[15:8], 1'b1, 1'b0);
    line(1'b0, 1'b1, 48);
  endtask

  initial begin
    int v0, f0;
    logic [15:0] b2b [4];
    b2b[0] = 16'hBEEF; b2b[1] = 16'h1357; b2b[2] = 16'h00FF; b2b[3] = 16'hC3A5;

    repeat (4) @(negedge clk);
    check("reset_p", 32'(p), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Basic word
    send_word(16'hA55A);
    check("basic_valid_cnt", 32'(vcnt), 32'd1);
    check("basic_p", 32'(p_last), 32'hA55A);
    check("basic_hold_p", 32'(p), 32'hA55A);
    check("basic_no_ferr", 32'(fcnt), 32'd0);

    // Start glitch, then a good word
    line(1'b0, 1'b0, 4);
    line(1'b0, 1'b1, 60);
    check("glitch_valid_cnt", 32'(vcnt), 32'd1);
    check("glitch_no_ferr", 32'(fcnt), 32'd0);
    send_word(16'h1122);
    check("glitch_next_cnt", 32'(vcnt), 32'd2);
    check("glitch_next_p", 32'(p_last), 32'h1122);

    // Good byte, framing error byte (drops partial word), then a good word
    send_frame(1'b0, 8'h99, 1'b1, 1'b0);
    send_frame(1'b0, 8'h77, 1'b0, 1'b0);
    line(1'b0, 1'b1, 32);
    check("ferr_cnt", 32'(fcnt), 32'd1);
    check("ferr_no_valid", 32'(vcnt), 32'd2);
    send_word(16'h1234);
    check("ferr_next_cnt", 32'(vcnt), 32'd3);
    check("ferr_next_p", 32'(p_last), 32'h1234);

    // Reset during bit 3 of second byte; line stays low across release
    send_frame(1'b0, 8'hEF, 1'b1, 1'b0);
    line(1'b0, 1'b0, 16);             // start bit
    line(1'b0, 1'b1, 16);             // bit0 of 0x55
    line(1'b0, 1'b0, 16);             // bit1
    line(1'b0, 1'b1, 16);             // bit2
    line(1'b0, 1'b0, 8);              // half of bit3
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_p", 32'(p), 32'h0);
    rst_n = 1'b1;
    v0 = vcnt;
    f0 = fcnt;
    line(1'b0, 1'b0, 40);
    line(1'b0, 1'b1, 40);
    check("rst_low_release_valid", 32'(vcnt - v0), 32'd0);
    check("rst_low_release_ferr", 32'(fcnt - f0), 32'd0);
    check("rst_wait_p", 32'(p), 32'h0);
    send_word(16'hABCD);
    check("rst_word_cnt", 32'(vcnt - v0), 32'd1);
    check("rst_word_p", 32'(p_last), 32'hABCD);

    // Back-to-back frames, no idle, CLKS_PER_BIT=4
    for (int w = 0; w < 4; w++) begin
      send_frame(1'b1, b2b[w][7:0], 1'b1, 1'b0);
      send_frame(1'b1, b2b[w][15:8], 1'b1, 1'b0);
    end
    line(1'b1, 1'b1, 16);
    check("b2b_valid_cnt", 32'(vcnt4), 32'd4);
    check("b2b_ferr", 32'(fcnt4), 32'd0);
    for (int w = 0; w < 4; w++) begin
      if (w < q4.size()) check($sformatf("b2b_p%0d", w), 32'(q4[w]), 32'(b2b[w]));
      else check($sformatf("b2b_missing%0d", w), 32'd0, 32'd1);
    end

`ifdef UART_RX_PARITY_EN
    v0 = vcnt;
    send_frame(1'b0, 8'h01, 1'b1, 1'b1); // parity bit 0: mismatch
    line(1'b0, 1'b1, 32);
    check("par_err_cnt", 32'(pcnt), 32'd1);
    check("par_no_ferr", 32'(fcnt), 32'd1);
    send_frame(1'b0, 8'h01, 1'b1, 1'b0); // parity bit 1: accepted
    send_frame(1'b0, 8'h02, 1'b1, 1'b0);
    line(1'b0, 1'b1, 48);
    check("par_ok_cnt", 32'(vcnt - v0), 32'd1);
    check("par_ok_p", 32'(p_last), 32'h0201);
    check("par_err_total", 32'(pcnt), 32'd1);
`else
    check("parity_err_never", 32'(pcnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
